ysyx_22050019_clint: RTL and testbench
======================================

// Module: ysyx_22050019_clint
// PURPOSE
//  Machine-mode interrupt source (core-local interruptor) feeding the CSR unit's trap inputs.
//  Holds mtime, mtimecmp and msip behind a single-outstanding valid/ready register port.
//  Drives level outputs mtip/msip toward the CSR/trap logic (future mip.MTIP/MSIP).
//  Sits on the core's MMIO path next to the data-memory port.
// PARAMETERS
//  TICK_DIV   2     clk cycles per mtime increment; legal 1..255 (1 = every cycle)
//  ADDR_W     16    width of req_addr (byte offset within CLINT window)
// PORTS
//  clk          in   1       core clock
//  rst_n        in   1       reset, ASYNCHRONOUS, ACTIVE-HIGH (asserted = 1, despite the name)
//  req_valid    in   1       request present
//  req_ready    out  1       CLINT can accept request this cycle
//  req_wen      in   1       1 = write, 0 = read
//  req_addr     in   ADDR_W  byte offset, 8-byte aligned (addr[2:0] ignored)
//  req_wdata    in   64      write data
//  req_wmask    in   8       byte-lane write enables, bit i -> wdata[8i+7:8i]
//  resp_valid   out  1       response present
//  resp_ready   in   1       requester accepts response
//  resp_rdata   out  64      read data (0 for writes)
//  resp_err     out  1       access to unmapped offset
//  mtip         out  1       timer interrupt pending = (mtime >= mtimecmp), unsigned
//  msip         out  1       software interrupt pending = msip_reg[0]
// BEHAVIOUR
//  Register map (offset aligned to 8): MSIP 0x0000 (bit0 only, rest read 0),
//   MTIMECMP 0x4000, MTIME 0xBFF8. Any other offset: read 0, write dropped, resp_err=1.
//  Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip_reg=0, prescaler=0,
//   state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mtip=0, msip=0.
//  FSM, 2 states:
//   IDLE: req_ready=1, resp_valid=0. req_valid=1 -> perform access at this edge, latch
//         rdata/err, go RESP.
//   RESP: req_ready=0, resp_valid=1, rdata/err stable. resp_ready=1 -> IDLE.
//  Latency: request accepted cycle N -> resp_valid high cycle N+1; min 2 cycles/transfer.
//   No back-to-back acceptance; requester must hold request while req_ready=0.
//  Read data = register value before the edge of acceptance (pre-tick, pre-write).
//  Writes: byte-masked merge, new = (old & ~M) | (wdata & M), M = mask expanded to bits.
//   wmask=0 write is legal and a no-op (still responds, err per address).
//   MSIP write uses lane 0 bit 0 only.
//  Prescaler: counts 0..TICK_DIV-1; mtime += 1 on the cycle prescaler==TICK_DIV-1, then wraps to 0.
//   mtime wraps 2^64-1 -> 0 silently.
//  Simultaneous MTIME write and tick: write wins, tick lost, prescaler continues counting.
//  mtip: registered compare, updated every cycle from post-update mtime/mtimecmp
//   (one cycle after the value change). Level, not sticky: rewriting mtimecmp above
//   mtime clears it. mtimecmp=all-ones -> mtip=1 only when mtime=all-ones.
//  msip: direct from msip_reg (changes cycle after write accept).
//  Reset mid-transaction: FSM to IDLE, in-flight response dropped, registers to reset values.
// STRUCTURE
//  Shared defines file (next to existing CSR_* defines): CLINT_MSIP 16'h0000,
//   CLINT_MTIMECMP 16'h4000, CLINT_MTIME 16'hBFF8; FSM state encodings.
//  Sub-module: ysyx_22050019_clint_tick (prescaler, outputs 1-cycle tick pulse).
//  Top holds mtime/mtimecmp/msip regs, decode, byte-mask merge, FSM, compare.
// TESTING
//  1 Reset, idle 20 cycles, TICK_DIV=2 -> read MTIME returns 9 or 10; mtip=0, msip=0, err=0.
//  2 Write MTIMECMP=64'd30, wmask=8'hFF -> mtip rises when mtime reaches 30 (cycle after);
//    then write MTIMECMP=64'd1000 -> mtip=0 next cycle.
//  3 Write MSIP wdata=1 -> msip=1; write wdata=64'hFFFF_FFFE -> msip=0; read MSIP -> 0.
//  4 Write MTIME=64'hFFFF_FFFF_FFFF_FFFF -> after <=2 cycles wraps, read returns small value;
//    write on tick edge -> written value seen, no extra increment.
//  5 Partial write MTIMECMP wmask=8'h0F wdata=64'h1122_3344_5566_7788 from all-ones
//    -> read 64'hFFFF_FFFF_5566_7788.
//  6 Read 0x1234 -> rdata=0, err=1; hold resp_ready=0 5 cycles -> resp_valid, rdata, err stable,
//    req_ready=0; assert rst_n mid-RESP -> resp_valid=0 and regs at reset values next cycle.

Source files
------------

// File: rtl/ysyx_22050019_clint_pkg.sv
// ysyx_22050019_clint_pkg: CLINT register offsets, FSM encoding and byte-lane merge helper.
package ysyx_22050019_clint_pkg;

    localparam logic [15:0] CLINT_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
    localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

    typedef enum logic {
        CLINT_IDLE = 1'b0,
        CLINT_RESP = 1'b1
    } clint_state_e;

    function automatic logic [63:0] wmerge(input logic [63:0] old, input logic [63:0] wdata,
                                           input logic [7:0] mask);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{mask[i]}};
        return (old & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/ysyx_22050019_clint_tick.sv
// ysyx_22050019_clint_tick: prescaler emitting a one-cycle pulse every TICK_DIV clocks.
module ysyx_22050019_clint_tick #(
    parameter int TICK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    logic [7:0] cnt_q;

    assign tick_o = cnt_q == 8'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) cnt_q <= '0;
        else cnt_q <= tick_o ? '0 : cnt_q + 8'd1;
    end

endmodule

// File: rtl/ysyx_22050019_clint.sv
// ysyx_22050019_clint: core-local interruptor with mtime/mtimecmp/msip behind a valid/ready port.
import ysyx_22050019_clint_pkg::*;

module ysyx_22050019_clint #(
    parameter int TICK_DIV = 2,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mtip,
    output logic              msip
);

    clint_state_e      state_q, state_d;
    logic [63:0]       mtime_q, mtime_d, mtimecmp_q, mtimecmp_d, rdata_q, rdata_d, rd;
    logic              msip_q, msip_d, err_q, err_d, mtip_q;
    logic              tick, acc, wr, sel_msip, sel_cmp, sel_mtime, hit;
    logic [ADDR_W-1:0] offs;

    ysyx_22050019_clint_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign offs      = req_addr & ~ADDR_W'(7);
    assign sel_msip  = offs == ADDR_W'(CLINT_MSIP);
    assign sel_cmp   = offs == ADDR_W'(CLINT_MTIMECMP);
    assign sel_mtime = offs == ADDR_W'(CLINT_MTIME);
    assign hit       = sel_msip | sel_cmp | sel_mtime;
    assign acc       = state_q == CLINT_IDLE && req_valid;
    assign wr        = acc && req_wen;

    // A write to MTIME overrides a coincident tick; the prescaler keeps running regardless.
    assign mtime_d    = wr && sel_mtime ? wmerge(mtime_q, req_wdata, req_wmask) : mtime_q + 64'(tick);
    assign mtimecmp_d = wr && sel_cmp ? wmerge(mtimecmp_q, req_wdata, req_wmask) : mtimecmp_q;
    assign msip_d     = wr && sel_msip && req_wmask[0] ? req_wdata[0] : msip_q;
    assign rd         = sel_msip ? {63'b0, msip_q} : sel_cmp ? mtimecmp_q : sel_mtime ? mtime_q : '0;
    assign rdata_d    = acc ? (req_wen ? '0 : rd) : rdata_q;
    assign err_d      = acc ? ~hit : err_q;
    assign state_d    = acc ? CLINT_RESP : (state_q == CLINT_RESP && resp_ready) ? CLINT_IDLE : state_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= CLINT_IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mtip_q     <= mtime_q >= mtimecmp_q;
        end
    end

    assign req_ready  = state_q == CLINT_IDLE;
    assign resp_valid = state_q == CLINT_RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mtip       = mtip_q;
    assign msip       = msip_q;

endmodule

// File: tb/tb_ysyx_22050019_clint.sv
// tb_ysyx_22050019_clint: directed scoreboard bench for the CLINT register port and interrupt levels.
module tb_ysyx_22050019_clint;

    localparam int TD = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b1;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        req_ready, resp_valid, resp_err, mtip, msip;
    logic [63:0] resp_rdata;

    typedef struct { logic [63:0] d; logic e; } exp_t;
    exp_t sb[$];

    int          checks = 0, errors = 0, cyc;
    logic [63:0] mt_base = '0;
    int          mt_edge = 0;

    ysyx_22050019_clint #(.TICK_DIV(TD), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .mtip(mtip), .msip(msip)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected MTIME value just before edge number acc, given the last write anchor.
    function automatic logic [63:0] mt_at(input int acc);
        return mt_base + 64'((acc - 1) / TD - mt_edge / TD);
    endfunction

    task automatic align(input int par);
        for (int n = 0; n < 10 && !(req_ready && (cyc + 1) % 2 == par); n++) @(negedge clk);
    endtask

    task automatic xact(input logic w, input logic [15:0] a, input logic [63:0] d, input logic [7:0] m,
                        input logic [63:0] ed, input logic ee, input logic is_mt, input string tag,
                        output int acc);
        exp_t e;
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = w; req_addr = a; req_wdata = d; req_wmask = m; resp_ready = 1'b1;
        acc = cyc + 1;
        sb.push_back('{is_mt ? mt_at(acc) : ed, ee});
        @(negedge clk);
        req_valid = 1'b0; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
        for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        e = sb.pop_front();
        chk({tag, " rdata"}, resp_rdata, e.d);
        chk({tag, " err"}, 64'(resp_err), 64'(e.e));
    endtask

    initial begin
        int   a;
        exp_t e;
        @(negedge clk); @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst rdata", resp_rdata, 64'd0);
        chk("rst err", 64'(resp_err), 64'd0);
        chk("rst mtip", 64'(mtip), 64'd0);
        chk("rst msip", 64'(msip), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        xact(1'b0, 16'hBFF8, '0, '0, '0, 1'b0, 1'b1, "t1 mtime", a);
        chk("t1 mtime range", 64'(resp_rdata == 64'd9 || resp_rdata == 64'd10), 64'd1);
        chk("t1 mtip", 64'(mtip), 64'd0);
        chk("t1 msip", 64'(msip), 64'd0);

        xact(1'b1, 16'h4000, 64'd30, 8'hFF, '0, 1'b0, 1'b0, "t2 cmp30", a);
        for (int n = 0; n < 100 && cyc < 60; n++) @(negedge clk);
        chk("t2 mtip at mtime=30", 64'(mtip), 64'd0);
        @(negedge clk);
        chk("t2 mtip cycle after", 64'(mtip), 64'd1);
        xact(1'b1, 16'h4000, 64'd1000, 8'hFF, '0, 1'b0, 1'b0, "t2 cmp1000", a);
        chk("t2 mtip lag", 64'(mtip), 64'd1);
        @(negedge clk);
        chk("t2 mtip cleared", 64'(mtip), 64'd0);

        xact(1'b1, 16'h0000, 64'd1, 8'hFF, '0, 1'b0, 1'b0, "t3 msip1", a);
        chk("t3 msip set", 64'(msip), 64'd1);
        xact(1'b1, 16'h0000, 64'hFFFF_FFFE, 8'hFF, '0, 1'b0, 1'b0, "t3 msip0", a);
        chk("t3 msip clr", 64'(msip), 64'd0);
        xact(1'b0, 16'h0000, '0, '0, 64'd0, 1'b0, 1'b0, "t3 msip rd", a);
        xact(1'b1, 16'h0000, 64'd1, 8'hFE, '0, 1'b0, 1'b0, "t3 msip lane1", a);
        chk("t3 msip masked", 64'(msip), 64'd0);

        align(1);
        xact(1'b1, 16'hBFF8, '1, 8'hFF, '0, 1'b0, 1'b0, "t4 mtime max", a);
        mt_base = '1; mt_edge = a;
        xact(1'b0, 16'hBFF8, '0, '0, '0, 1'b0, 1'b1, "t4 wrap rd", a);
        chk("t4 wrap small", 64'(resp_rdata < 64'd4), 64'd1);
        align(0);
        xact(1'b1, 16'hBFF8, 64'h100, 8'hFF, '0, 1'b0, 1'b0, "t4 tickedge wr", a);
        mt_base = 64'h100; mt_edge = a;
        xact(1'b0, 16'hBFF8, '0, '0, '0, 1'b0, 1'b1, "t4 tickedge rd", a);
        xact(1'b0, 16'hBFFC, '0, '0, '0, 1'b0, 1'b1, "t4 low-bits ignored", a);

        xact(1'b1, 16'h4000, '1, 8'hFF, '0, 1'b0, 1'b0, "t5 cmp ones", a);
        xact(1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'h0F, '0, 1'b0, 1'b0, "t5 partial", a);
        xact(1'b0, 16'h4000, '0, '0, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b0, "t5 cmp rd", a);
        xact(1'b1, 16'h4000, 64'd0, 8'h00, '0, 1'b0, 1'b0, "t5 mask0", a);
        xact(1'b0, 16'h4000, '0, '0, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b0, "t5 mask0 rd", a);
        xact(1'b1, 16'h0008, '1, 8'hFF, 64'd0, 1'b1, 1'b0, "t5 unmapped wr", a);
        chk("t5 mtip", 64'(mtip), 64'd0);

        xact(1'b1, 16'h0000, 64'd1, 8'h01, '0, 1'b0, 1'b0, "t6 msip1", a);
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 16'h1234; resp_ready = 1'b0;
        sb.push_back('{64'd0, 1'b1});
        @(negedge clk);
        req_valid = 1'b0;
        e = sb[0];
        repeat (5) begin
            chk("t6 hold resp_valid", 64'(resp_valid), 64'd1);
            chk("t6 hold req_ready", 64'(req_ready), 64'd0);
            chk("t6 hold rdata", resp_rdata, e.d);
            chk("t6 hold err", 64'(resp_err), 64'(e.e));
            @(negedge clk);
        end
        rst = 1'b1;
        sb.delete();
        #1;
        chk("t6 rst resp_valid", 64'(resp_valid), 64'd0);
        chk("t6 rst req_ready", 64'(req_ready), 64'd1);
        chk("t6 rst err", 64'(resp_err), 64'd0);
        chk("t6 rst msip", 64'(msip), 64'd0);
        chk("t6 rst mtip", 64'(mtip), 64'd0);
        @(negedge clk);
        rst = 1'b0; resp_ready = 1'b1; mt_base = '0; mt_edge = 0;
        xact(1'b0, 16'h4000, '0, '0, '1, 1'b0, 1'b0, "t6 cmp reset", a);
        xact(1'b0, 16'h0000, '0, '0, 64'd0, 1'b0, 1'b0, "t6 msip reset", a);
        xact(1'b0, 16'hBFF8, '0, '0, '0, 1'b0, 1'b1, "t6 mtime reset", a);
        chk("sb drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
